bullet_pool_ctrl: RTL and testbench

//  Per-tank bullet manager: up to NUM_BULLETS simultaneous bullets, each slot with its own lifecycle FSM.

---
 rtl/bullet_pool_ctrl_if.sv | 30 +++
 rtl/bullet_pool_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_bullet_pool_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_pool_ctrl_if.sv
// Keyboard, collision and bullet status bundle for one tank's bullet pool.
// The master side (keyboard/collision logic) drives requests; the slave side (bullet_pool_ctrl) reports slot status.
interface bullet_pool_ctrl_if #(
  parameter int NUM_BULLETS = 3
);
  localparam int SLOT_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  logic [7:0]             keycode1;
  logic [7:0]             keycode2;
  logic [7:0]             keycode3;
  logic [7:0]             keycode4;
  logic [NUM_BULLETS-1:0] wall_hit;
  logic [NUM_BULLETS-1:0] tank_hit;
  logic [NUM_BULLETS-1:0] bullet_active;
  logic [NUM_BULLETS-1:0] bullet_launch;
  logic                   fire_pulse;
  logic [SLOT_W-1:0]      fire_slot;
  logic [SLOT_W:0]        free_count;
  logic                   cooldown_busy;

  modport master (
    output keycode1, keycode2, keycode3, keycode4, wall_hit, tank_hit,
    input  bullet_active, bullet_launch, fire_pulse, fire_slot, free_count, cooldown_busy
  );

  modport slave (
    input  keycode1, keycode2, keycode3, keycode4, wall_hit, tank_hit,
    output bullet_active, bullet_launch, fire_pulse, fire_slot, free_count, cooldown_busy
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// Per-tank bullet pool: fire-key detection, cooldown, lowest-free-slot allocation and per-slot lifecycle.
// Define BULLET_AUTOFIRE_EN to fire on the key level (autofire) instead of its rising edge.
module bullet_pool_ctrl #(
  parameter int         NUM_BULLETS = 3,
  parameter logic [7:0] FIRE_KEY    = 8'd40,
  parameter int         COOLDOWN    = 4,
  parameter int         LIFETIME    = 60
) (
  input logic               fsm_clock,
  input logic               reset,
  bullet_pool_ctrl_if.slave bus
);
  localparam int SLOT_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int LIFE_W = $clog2(LIFETIME);
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_FLYING = 2'd2;

  logic                                key_now_s;
  logic                                key_prev_r;
  logic                                fire_req_s;
  logic                                grant_s;
  logic                                any_idle_s;
  logic [SLOT_W-1:0]                   grant_idx_s;
  logic [NUM_BULLETS-1:0]              idle_s;
  logic [NUM_BULLETS-1:0]              hit_s;
  logic [NUM_BULLETS-1:0][1:0]         state_r;
  logic [NUM_BULLETS-1:0][1:0]         state_nxt_s;
  logic [NUM_BULLETS-1:0][LIFE_W-1:0]  life_r;
  logic [NUM_BULLETS-1:0][LIFE_W-1:0]  life_nxt_s;
  logic [CD_W-1:0]                     cooldown_r;
  logic [CD_W-1:0]                     cooldown_nxt_s;
  logic [NUM_BULLETS-1:0]              active_r;
  logic [NUM_BULLETS-1:0]              launch_r;
  logic                                fire_pulse_r;
  logic [SLOT_W-1:0]                   fire_slot_r;
  logic [SLOT_W:0]                     free_count_r;
  logic                                busy_r;

  function automatic logic [NUM_BULLETS-1:0] decode_active(input logic [NUM_BULLETS-1:0][1:0] st);
    logic [NUM_BULLETS-1:0] v;
    v = {NUM_BULLETS{1'b0}};
    for (int i = 0; i < NUM_BULLETS; i++) begin
      v[i] = (st[i] == ST_LAUNCH) || (st[i] == ST_FLYING);
    end
    return v;
  endfunction

  function automatic logic [NUM_BULLETS-1:0] decode_launch(input logic [NUM_BULLETS-1:0][1:0] st);
    logic [NUM_BULLETS-1:0] v;
    v = {NUM_BULLETS{1'b0}};
    for (int i = 0; i < NUM_BULLETS; i++) begin
      v[i] = (st[i] == ST_LAUNCH);
    end
    return v;
  endfunction

  function automatic logic [SLOT_W:0] count_idle(input logic [NUM_BULLETS-1:0][1:0] st);
    logic [SLOT_W:0] cnt;
    cnt = {(SLOT_W+1){1'b0}};
    for (int i = 0; i < NUM_BULLETS; i++) begin
      cnt = cnt + ((st[i] == ST_IDLE) ? (SLOT_W+1)'(1'b1) : {(SLOT_W+1){1'b0}});
    end
    return cnt;
  endfunction

  assign key_now_s = (bus.keycode1 == FIRE_KEY) || (bus.keycode2 == FIRE_KEY) ||
                     (bus.keycode3 == FIRE_KEY) || (bus.keycode4 == FIRE_KEY);

`ifdef BULLET_AUTOFIRE_EN
  assign fire_req_s = key_now_s;
`else
  assign fire_req_s = key_now_s & ~key_prev_r;
`endif

  // Eligibility uses pre-edge state, so a slot retiring this edge cannot be re-granted until next edge.
  always_comb begin
    idle_s = {NUM_BULLETS{1'b0}};
    hit_s  = {NUM_BULLETS{1'b0}};
    for (int i = 0; i < NUM_BULLETS; i++) begin
      idle_s[i] = (state_r[i] == ST_IDLE);
      hit_s[i]  = bus.wall_hit[i] | bus.tank_hit[i];
    end
  end

  // Priority pick of the lowest-index idle slot.
  always_comb begin
    grant_idx_s = {SLOT_W{1'b0}};
    any_idle_s  = 1'b0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      grant_idx_s = idle_s[i] ? SLOT_W'(i) : grant_idx_s;
      any_idle_s  = any_idle_s | idle_s[i];
    end
    grant_s = fire_req_s && (cooldown_r == {CD_W{1'b0}}) && any_idle_s;
  end

  // Cooldown reloads on grant and otherwise counts down to zero.
  always_comb begin
    cooldown_nxt_s = cooldown_r;
    if (grant_s) begin
      cooldown_nxt_s = CD_W'(COOLDOWN);
    end else if (cooldown_r != {CD_W{1'b0}}) begin
      cooldown_nxt_s = cooldown_r - CD_W'(1'b1);
    end else begin
      cooldown_nxt_s = {CD_W{1'b0}};
    end
  end

  // Slot lifecycle; a hit overrides expiry, and life counts down through LAUNCH and FLYING.
  always_comb begin
    state_nxt_s = state_r;
    life_nxt_s  = life_r;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      case (state_r[i])
        ST_IDLE: begin
          if (grant_s && (grant_idx_s == SLOT_W'(i))) begin
            state_nxt_s[i] = ST_LAUNCH;
            life_nxt_s[i]  = LIFE_W'(LIFETIME - 1);
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          if (hit_s[i]) begin
            state_nxt_s[i] = ST_IDLE;
          end else begin
            state_nxt_s[i] = ST_FLYING;
            life_nxt_s[i]  = life_r[i] - LIFE_W'(1'b1);
          end
        end
        ST_FLYING: begin
          if (hit_s[i] || (life_r[i] == {LIFE_W{1'b0}})) begin
            state_nxt_s[i] = ST_IDLE;
          end else begin
            state_nxt_s[i] = ST_FLYING;
            life_nxt_s[i]  = life_r[i] - LIFE_W'(1'b1);
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
          life_nxt_s[i]  = {LIFE_W{1'b0}};
        end
      endcase
    end
  end

  // State and outputs registered together; outputs are decoded from the next state so they track the regs.
  always_ff @(posedge fsm_clock) begin
    if (reset) begin
      state_r      <= {NUM_BULLETS{ST_IDLE}};
      life_r       <= {(NUM_BULLETS*LIFE_W){1'b0}};
      cooldown_r   <= {CD_W{1'b0}};
      key_prev_r   <= 1'b0;
      active_r     <= {NUM_BULLETS{1'b0}};
      launch_r     <= {NUM_BULLETS{1'b0}};
      fire_pulse_r <= 1'b0;
      fire_slot_r  <= {SLOT_W{1'b0}};
      free_count_r <= (SLOT_W+1)'(NUM_BULLETS);
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      life_r       <= life_nxt_s;
      cooldown_r   <= cooldown_nxt_s;
      key_prev_r   <= key_now_s;
      active_r     <= decode_active(state_nxt_s);
      launch_r     <= decode_launch(state_nxt_s);
      fire_pulse_r <= grant_s;
      fire_slot_r  <= grant_s ? grant_idx_s : fire_slot_r;
      free_count_r <= count_idle(state_nxt_s);
      busy_r       <= (cooldown_nxt_s != {CD_W{1'b0}});
    end
  end

  assign bus.bullet_active = active_r;
  assign bus.bullet_launch = launch_r;
  assign bus.fire_pulse    = fire_pulse_r;
  assign bus.fire_slot     = fire_slot_r;
  assign bus.free_count    = free_count_r;
  assign bus.cooldown_busy = busy_r;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Self-checking bench for bullet_pool_ctrl: directed scenarios plus randomized traffic against a
// slot model that tracks each bullet's remaining active cycles and age.
module tb_bullet_pool_ctrl;
  localparam int         NB = 3;
  localparam int         LT = 60;
  localparam int         CD = 4;
  localparam logic [7:0] FK = 8'd40;

  logic fsm_clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Model: remaining active cycles per slot (0 = free), cycles since launch, cooldown, key history.
  int m_rem [NB];
  int m_age [NB];
  int m_cd;
  bit m_prev;
  bit m_pulse;
  int m_slot;

  bullet_pool_ctrl_if #(.NUM_BULLETS(NB)) bus ();

  bullet_pool_ctrl #(
    .NUM_BULLETS(NB), .FIRE_KEY(FK), .COOLDOWN(CD), .LIFETIME(LT)
  ) dut (
    .fsm_clock(fsm_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 fsm_clock = ~fsm_clock;

  function automatic logic [NB-1:0] exp_active();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (m_rem[i] > 0);
    return v;
  endfunction

  function automatic logic [NB-1:0] exp_launch();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (m_rem[i] > 0) && (m_age[i] == 0);
    return v;
  endfunction

  function automatic int exp_free();
    int n;
    n = 0;
    for (int i = 0; i < NB; i++) if (m_rem[i] == 0) n++;
    return n;
  endfunction

  task automatic idle_inputs();
    bus.keycode1 = 8'd0;
    bus.keycode2 = 8'd0;
    bus.keycode3 = 8'd0;
    bus.keycode4 = 8'd0;
    bus.wall_hit = '0;
    bus.tank_hit = '0;
  endtask

  // One clock edge: advance the model from the inputs present at the edge, return at the falling edge.
  task automatic tick();
    bit kn, req, g;
    int idx;
    @(posedge fsm_clock);
    if (reset) begin
      for (int i = 0; i < NB; i++) begin m_rem[i] = 0; m_age[i] = 0; end
      m_cd = 0; m_prev = 1'b0; m_pulse = 1'b0; m_slot = 0;
    end else begin
      kn = (bus.keycode1 == FK) || (bus.keycode2 == FK) || (bus.keycode3 == FK) || (bus.keycode4 == FK);
`ifdef BULLET_AUTOFIRE_EN
      req = kn;
`else
      req = kn && !m_prev;
`endif
      m_prev = kn;
      idx = -1;
      for (int i = NB - 1; i >= 0; i--) if (m_rem[i] == 0) idx = i;
      g = req && (m_cd == 0) && (idx >= 0);
      for (int i = 0; i < NB; i++) begin
        if (m_rem[i] > 0) begin
          if (bus.wall_hit[i] || bus.tank_hit[i]) m_rem[i] = 0;
          else begin m_rem[i]--; m_age[i]++; end
        end
      end
      m_cd = g ? CD : ((m_cd > 0) ? m_cd - 1 : 0);
      if (g) begin m_rem[idx] = LT; m_age[idx] = 0; m_slot = idx; end
      m_pulse = g;
    end
    @(negedge fsm_clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.bullet_active !== 3'b000) begin failures++; $display("FAIL reset_active: got %b expected 000", bus.bullet_active); end
    checks++; if (bus.bullet_launch !== 3'b000) begin failures++; $display("FAIL reset_launch: got %b expected 000", bus.bullet_launch); end
    checks++; if (bus.fire_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", bus.fire_pulse); end
    checks++; if (bus.fire_slot !== 2'd0) begin failures++; $display("FAIL reset_slot: got %0d expected 0", bus.fire_slot); end
    checks++; if (bus.free_count !== 3'd3) begin failures++; $display("FAIL reset_free: got %0d expected 3", bus.free_count); end
    checks++; if (bus.cooldown_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.cooldown_busy); end
  endtask

  task automatic test_single_fire();
    do_reset();
    bus.keycode3 = FK;
    tick();
    bus.keycode3 = 8'd0;
    checks++; if (bus.fire_pulse !== 1'b1) begin failures++; $display("FAIL single_pulse: got %b expected 1", bus.fire_pulse); end
    checks++; if (bus.fire_slot !== 2'd0) begin failures++; $display("FAIL single_slot: got %0d expected 0", bus.fire_slot); end
    checks++; if (bus.bullet_active !== 3'b001) begin failures++; $display("FAIL single_active: got %b expected 001", bus.bullet_active); end
    checks++; if (bus.bullet_launch !== 3'b001) begin failures++; $display("FAIL single_launch: got %b expected 001", bus.bullet_launch); end
    checks++; if (bus.cooldown_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bus.cooldown_busy); end
    tick();
    checks++; if (bus.bullet_launch !== 3'b000) begin failures++; $display("FAIL single_launch_drop: got %b expected 000", bus.bullet_launch); end
    checks++; if (bus.fire_pulse !== 1'b0) begin failures++; $display("FAIL single_pulse_drop: got %b expected 0", bus.fire_pulse); end
  endtask

  task automatic test_lifetime();
    int cnt;
    do_reset();
    bus.keycode4 = FK;
    tick();
    bus.keycode4 = 8'd0;
    cnt = 0;
    for (int k = 0; k < 200 && bus.bullet_active[0] === 1'b1; k++) begin
      cnt++;
      tick();
    end
    checks++; if (cnt != LT) begin failures++; $display("FAIL lifetime_cycles: got %0d expected %0d", cnt, LT); end
    checks++; if (bus.free_count !== 3'd3) begin failures++; $display("FAIL lifetime_free: got %0d expected 3", bus.free_count); end
  endtask

  task automatic test_toggle_spacing();
    int nfires, last;
    do_reset();
    nfires = 0;
    last = -100;
    for (int c = 0; c < 30; c++) begin
      bus.keycode1 = (c % 2 == 0) ? FK : 8'd0;
      tick();
      checks++; if (bus.fire_pulse !== m_pulse) begin failures++; $display("FAIL toggle_pulse c=%0d: got %b expected %b", c, bus.fire_pulse, m_pulse); end
      if (bus.fire_pulse === 1'b1) begin
        checks++; if (c - last < CD + 1) begin failures++; $display("FAIL toggle_spacing: got %0d expected >=%0d", c - last, CD + 1); end
        checks++; if (bus.fire_slot !== 2'(nfires)) begin failures++; $display("FAIL toggle_slot: got %0d expected %0d", bus.fire_slot, nfires); end
        last = c;
        nfires++;
      end
    end
    bus.keycode1 = 8'd0;
    checks++; if (nfires != 3) begin failures++; $display("FAIL toggle_fires: got %0d expected 3", nfires); end
    checks++; if (bus.free_count !== 3'd0) begin failures++; $display("FAIL toggle_free: got %0d expected 0", bus.free_count); end
  endtask

  task automatic test_hit_same_edge();
    do_reset();
    bus.keycode1 = FK; tick(); bus.keycode1 = 8'd0;
    for (int k = 0; k < 5; k++) tick();
    bus.keycode1 = FK; tick(); bus.keycode1 = 8'd0;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bus.bullet_active !== 3'b011) begin failures++; $display("FAIL hit_setup: got %b expected 011", bus.bullet_active); end
    bus.wall_hit = 3'b001;
    tick();
    bus.wall_hit = 3'b000;
    checks++; if (bus.bullet_active !== 3'b010) begin failures++; $display("FAIL hit_wall: got %b expected 010", bus.bullet_active); end
    bus.tank_hit = 3'b010;
    bus.keycode1 = FK;
    tick();
    bus.tank_hit = 3'b000;
    bus.keycode1 = 8'd0;
    checks++; if (bus.fire_pulse !== 1'b1) begin failures++; $display("FAIL hit_fire_pulse: got %b expected 1", bus.fire_pulse); end
    checks++; if (bus.fire_slot !== 2'd0) begin failures++; $display("FAIL hit_fire_slot: got %0d expected 0", bus.fire_slot); end
    checks++; if (bus.bullet_active !== 3'b001) begin failures++; $display("FAIL hit_active: got %b expected 001", bus.bullet_active); end
    checks++; if (bus.bullet_launch !== 3'b001) begin failures++; $display("FAIL hit_launch: got %b expected 001", bus.bullet_launch); end
  endtask

  task automatic test_held_key();
    int nfires, first;
    do_reset();
    nfires = 0;
    first = -1;
    bus.keycode2 = FK;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (bus.fire_pulse !== m_pulse) begin failures++; $display("FAIL held_pulse c=%0d: got %b expected %b", c, bus.fire_pulse, m_pulse); end
      if (bus.fire_pulse === 1'b1) begin
        if (first < 0) first = c;
        nfires++;
      end
    end
    bus.keycode2 = 8'd0;
    checks++; if (first != 0) begin failures++; $display("FAIL held_first: got %0d expected 0", first); end
`ifdef BULLET_AUTOFIRE_EN
    checks++; if (nfires != 3) begin failures++; $display("FAIL held_fires: got %0d expected 3", nfires); end
`else
    checks++; if (nfires != 1) begin failures++; $display("FAIL held_fires: got %0d expected 1", nfires); end
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.keycode1 = FK; tick(); bus.keycode1 = 8'd0;
    for (int k = 0; k < 5; k++) tick();
    bus.keycode1 = FK; tick(); bus.keycode1 = 8'd0;
    checks++; if (bus.bullet_active !== 3'b011) begin failures++; $display("FAIL mid_setup: got %b expected 011", bus.bullet_active); end
    reset = 1'b1;
    tick();
    checks++; if (bus.bullet_active !== 3'b000) begin failures++; $display("FAIL mid_active: got %b expected 000", bus.bullet_active); end
    checks++; if (bus.cooldown_busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", bus.cooldown_busy); end
    checks++; if (bus.free_count !== 3'd3) begin failures++; $display("FAIL mid_free: got %0d expected 3", bus.free_count); end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.keycode1 = ($urandom_range(0, 3) == 0) ? FK : 8'($urandom_range(0, 255));
      bus.keycode2 = ($urandom_range(0, 7) == 0) ? FK : 8'd0;
      bus.keycode3 = 8'($urandom_range(0, 255));
      bus.keycode4 = ($urandom_range(0, 7) == 0) ? FK : 8'd0;
      for (int i = 0; i < NB; i++) begin
        bus.wall_hit[i] = ($urandom_range(0, 31) == 0);
        bus.tank_hit[i] = ($urandom_range(0, 31) == 0);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (bus.bullet_active !== exp_active()) begin failures++; $display("FAIL rnd_active c=%0d: got %b expected %b", c, bus.bullet_active, exp_active()); end
      checks++; if (bus.bullet_launch !== exp_launch()) begin failures++; $display("FAIL rnd_launch c=%0d: got %b expected %b", c, bus.bullet_launch, exp_launch()); end
      checks++; if (bus.fire_pulse !== m_pulse) begin failures++; $display("FAIL rnd_pulse c=%0d: got %b expected %b", c, bus.fire_pulse, m_pulse); end
      checks++; if (bus.fire_slot !== 2'(m_slot)) begin failures++; $display("FAIL rnd_slot c=%0d: got %0d expected %0d", c, bus.fire_slot, m_slot); end
      checks++; if (bus.free_count !== 3'(exp_free())) begin failures++; $display("FAIL rnd_free c=%0d: got %0d expected %0d", c, bus.free_count, exp_free()); end
      checks++; if (bus.cooldown_busy !== (m_cd != 0)) begin failures++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, bus.cooldown_busy, m_cd != 0); end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NB; i++) begin m_rem[i] = 0; m_age[i] = 0; end
    m_cd = 0; m_prev = 1'b0; m_pulse = 1'b0; m_slot = 0;
    test_reset();
    test_single_fire();
    test_lifetime();
    test_toggle_spacing();
    test_hit_same_edge();
    test_held_key();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
